// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: groups the requester-side and FIFO-side signals of the write arbiter.
// Latency: none; this is a bundle of wires.
// Backpressure: carried by req_ready (per requester) and full (from the FIFO).
//
// Ports/signals:
//   req, req_valid, req_last : per-requester request / byte-valid / last-byte flags (4 bits)
//   req_data                 : four DSIZE slices, requester i on [i*DSIZE +: DSIZE]
//   req_ready, grant         : per-requester accept strobe and registered one-hot owner
//   full, abort              : FIFO full flag and packet-drop request
//   write_data, write_enable : FIFO write port
//   clear, pkt_err           : FIFO clear pulse and length-overrun pulse
// Modports: slave = the arbiter, master = the requesters plus FIFO environment.
interface fifo_write_arbiter_if #(
  parameter int DSIZE = 8
) ();

  logic [3:0]         req;
  logic [4*DSIZE-1:0] req_data;
  logic [3:0]         req_valid;
  logic [3:0]         req_last;
  logic [3:0]         req_ready;
  logic [3:0]         grant;
  logic               full;
  logic [DSIZE-1:0]   write_data;
  logic               write_enable;
  logic               abort;
  logic               clear;
  logic               pkt_err;

  modport slave (
    input  req, req_data, req_valid, req_last, full, abort,
    output req_ready, grant, write_data, write_enable, clear, pkt_err
  );

  modport master (
    output req, req_data, req_valid, req_last, full, abort,
    input  req_ready, grant, write_data, write_enable, clear, pkt_err
  );

endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: gives one of four requesters ownership of a FIFO write port for a whole packet.
// Latency: grant appears one cycle after arbitration; owner bytes reach write_data/write_enable combinationally.
// Backpressure: full or abort stalls the owner through req_ready; ownership is held until last byte, overrun or abort.
//
// Ports:
//   clk  : single clock, all state on the rising edge
//   rst  : synchronous, active-low reset
//   bus  : fifo_write_arbiter_if.slave
//            in : req, req_data, req_valid, req_last, full, abort
//            out: req_ready, grant, write_data, write_enable, clear, pkt_err
// Parameters: DSIZE (data width), MAX_PKT (bytes per packet before overrun, 2..1024).
// Build option: define FIFO_ARB_PRIORITY_EN to let requester 0 win every arbitration it takes part in;
//   the remaining requesters stay round-robin and a requester-0 packet leaves rr_ptr untouched.
module fifo_write_arbiter #(
  parameter int DSIZE   = 8,
  parameter int MAX_PKT = 64
) (
  input logic                 clk,
  input logic                 rst,
  fifo_write_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_PKT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      grant_q;
  logic [1:0]      owner;
  logic [1:0]      rr_ptr;
  logic [CW-1:0]   byte_cnt;
  logic            clear_q;
  logic            pkt_err_q;

  // ---------------------------------------------------------------------------
  // Round-robin search: first requester at or after ptr, wrapping mod 4.
  // Returns {found, index}. The loop runs from the farthest candidate down so
  // the nearest one to ptr is the last assignment and therefore wins.
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0] pick_res;
  logic       pick_vld;
  logic [1:0] pick_idx;

  always_comb begin
    pick_res = rr_pick(bus.req, rr_ptr);
`ifdef FIFO_ARB_PRIORITY_EN
    if (bus.req[0]) pick_res = 3'b100;
`endif
  end

  assign pick_vld = pick_res[2];
  assign pick_idx = pick_res[1:0];

  // Pointer value the next arbitration starts from once the owner releases.
  logic [1:0] ptr_after;
`ifdef FIFO_ARB_PRIORITY_EN
  assign ptr_after = (owner == 2'd0) ? rr_ptr : owner + 2'd1;
`else
  assign ptr_after = owner + 2'd1;
`endif

  // ---------------------------------------------------------------------------
  // Datapath: only the owner's slice is forwarded, and only while in XFER.
  // Abort masks acceptance in the same cycle it is raised.
  // ---------------------------------------------------------------------------
  logic             in_xfer;
  logic [DSIZE-1:0] owner_data;
  logic             accept;
  logic             at_max;
  logic             pkt_end;

  assign in_xfer    = (state == XFER);
  assign owner_data = bus.req_data[owner*DSIZE +: DSIZE];
  assign accept     = in_xfer & bus.req_valid[owner] & ~bus.full & ~bus.abort;

  // byte_cnt holds bytes already accepted, so the byte being accepted now is
  // number MAX_PKT when the counter reads MAX_PKT-1.
  assign at_max  = (byte_cnt == CW'(MAX_PKT - 1));
  assign pkt_end = accept & (bus.req_last[owner] | at_max);

  assign bus.write_enable = accept;
  assign bus.write_data   = in_xfer ? owner_data : '0;
  assign bus.req_ready    = accept ? (4'b0001 << owner) : 4'b0000;
  assign bus.grant        = grant_q;
  assign bus.clear        = clear_q;
  assign bus.pkt_err      = pkt_err_q;

  // ---------------------------------------------------------------------------
  // Control FSM. grant/clear/pkt_err are registered here; clear and pkt_err
  // default low so each is a single-cycle pulse. Going back to IDLE always
  // drops grant, which guarantees an idle cycle between packets.
  // Reset drops ownership without pulsing clear; the FIFO has its own reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      grant_q   <= 4'b0000;
      owner     <= 2'd0;
      rr_ptr    <= 2'd0;
      byte_cnt  <= '0;
      clear_q   <= 1'b0;
      pkt_err_q <= 1'b0;
    end else begin
      clear_q   <= 1'b0;
      pkt_err_q <= 1'b0;
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          if (pick_vld) begin
            owner   <= pick_idx;
            grant_q <= 4'b0001 << pick_idx;
            state   <= XFER;
          end
        end

        XFER: begin
          // req[owner] dropping is deliberately ignored: the packet ends only
          // on last byte, overrun or abort.
          if (bus.abort) begin
            state    <= FLUSH;
            grant_q  <= 4'b0000;
            clear_q  <= 1'b1;
            byte_cnt <= '0;
          end else if (pkt_end) begin
            state     <= IDLE;
            grant_q   <= 4'b0000;
            rr_ptr    <= ptr_after;
            byte_cnt  <= '0;
            // Reaching the limit without a last marker is an overrun.
            pkt_err_q <= ~bus.req_last[owner];
          end else if (accept) begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end

        FLUSH: begin
          // clear is high for exactly this one cycle; abort here is ignored.
          state  <= IDLE;
          rr_ptr <= ptr_after;
        end

        default: begin
          state   <= IDLE;
          grant_q <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed scenarios followed by random traffic, checked every cycle
// against a packet-level reference model (owner, bytes sent, pointer) kept in plain integers.
module tb_fifo_write_arbiter;

  localparam int DSIZE = 8;
  localparam int MAXP  = 4;
`ifdef FIFO_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.DSIZE(DSIZE)) bus ();

  fifo_write_arbiter #(.DSIZE(DSIZE), .MAX_PKT(MAXP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: who owns the port (-1 none), bytes delivered in the
  // current packet, where the next search starts, and pending pulses.
  int m_own   = -1;
  int m_bytes = 0;
  int m_ptr   = 0;
  bit m_flush = 1'b0;
  bit m_err   = 1'b0;

  bit         chk_on = 1'b0;
  logic [3:0] prev_grant = 4'b0000;
  int         n_wr, n_clr, n_err;
  logic [7:0] wq[$];
  logic [3:0] gq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input int ptr, input logic [3:0] r);
    if (PRIO && r[0]) return 0;
    for (int k = 0; k < 4; k++)
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  function automatic int next_ptr(input int own, input int ptr);
    return (PRIO && own == 0) ? ptr : (own + 1) % 4;
  endfunction

  function automatic logic [3:0] gq_at(input int i);
    if (i < gq.size()) return gq[i];
    return 4'hx;
  endfunction

  function automatic logic [7:0] wq_at(input int i);
    if (i < wq.size()) return wq[i];
    return 8'hxx;
  endfunction

  task automatic clr_logs();
    n_wr = 0; n_clr = 0; n_err = 0;
    wq.delete(); gq.delete();
  endtask

  // One clock cycle: drive after the falling edge, check 1ns later, then
  // advance the model to what the coming rising edge should produce.
  task automatic step(input logic [3:0] r, input logic [3:0] v, input logic [3:0] l,
                      input logic f, input logic a, input logic rs, input logic [31:0] d);
    logic [3:0] eg, er;
    logic       ew;
    logic [7:0] ed;
    int         o;
    bit         nf, ne;
    @(negedge clk);
    bus.req = r; bus.req_valid = v; bus.req_last = l;
    bus.full = f; bus.abort = a; bus.req_data = d; rst = rs;
    #1;
    o  = m_own;
    eg = (o >= 0) ? 4'(1 << o) : 4'b0000;
    ew = (o >= 0) && v[o] && !f && !a;
    ed = (o >= 0) ? d[o*8 +: 8] : 8'h00;
    er = ew ? 4'(1 << o) : 4'b0000;
    if (chk_on) begin
      chk("grant",        32'(bus.grant),        32'(eg));
      chk("write_enable", 32'(bus.write_enable), 32'(ew));
      chk("write_data",   32'(bus.write_data),   32'(ed));
      chk("req_ready",    32'(bus.req_ready),    32'(er));
      chk("clear",        32'(bus.clear),        32'(m_flush));
      chk("pkt_err",      32'(bus.pkt_err),      32'(m_err));
    end
    if (bus.write_enable === 1'b1) begin n_wr++; wq.push_back(bus.write_data); end
    if (bus.clear === 1'b1) n_clr++;
    if (bus.pkt_err === 1'b1) n_err++;
    if (prev_grant == 4'b0000 && bus.grant != 4'b0000) gq.push_back(bus.grant);
    prev_grant = bus.grant;

    nf = 1'b0; ne = 1'b0;
    if (!rs) begin
      m_own = -1; m_bytes = 0; m_ptr = 0;
    end else if (m_own >= 0) begin
      if (a) begin
        nf = 1'b1; m_ptr = next_ptr(m_own, m_ptr); m_own = -1; m_bytes = 0;
      end else if (ew) begin
        m_bytes++;
        if (l[m_own] || m_bytes == MAXP) begin
          ne = !l[m_own];
          m_ptr = next_ptr(m_own, m_ptr); m_own = -1; m_bytes = 0;
        end
      end
    end else if (!m_flush) begin
      m_own = pick(m_ptr, r);
    end
    m_flush = nf;
    m_err   = ne;
  endtask

  initial begin
    logic [3:0] rr;
    int fcnt;

    // Reset: first cycle leaves the DUT state unknown, so only later cycles are checked.
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_on = 1'b1;
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset_grant", 32'(bus.grant), 32'h0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0);

    // Requesters 1 and 2 held, 3-byte packets: 0010, 0100, 0010 with idle gaps.
    clr_logs();
    for (int c = 0; c < 12; c++)
      step(4'b0110, 4'hF, (m_bytes == 2) ? 4'hF : 4'h0, 1'b0, 1'b0, 1'b1, $urandom);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("rr_grants", 32'(gq.size()), 32'd3);
    chk("rr_g0", 32'(gq_at(0)), 32'h2);
    chk("rr_g1", 32'(gq_at(1)), 32'h4);
    chk("rr_g2", 32'(gq_at(2)), 32'h2);
    chk("rr_writes", 32'(n_wr), 32'd9);

    // Owner 1, 4 bytes, full high for 2 cycles on byte 2.
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    clr_logs();
    fcnt = 0;
    for (int c = 0; c < 10; c++) begin
      logic fz;
      fz = (m_own == 1 && m_bytes == 1 && fcnt < 2);
      if (fz) fcnt++;
      step((n_wr < 4) ? 4'b0010 : 4'b0000, 4'hF, (m_bytes == 3) ? 4'b0010 : 4'b0000,
           fz, 1'b0, 1'b1, 32'(8'hA0 + 8'(m_bytes)) << 8);
    end
    chk("full_writes", 32'(n_wr), 32'd4);
    for (int i = 0; i < 4; i++) chk("full_order", 32'(wq_at(i)), 32'(8'hA0 + 8'(i)));
    chk("full_no_err", 32'(n_err), 32'd0);

    // Overrun: requester 2 offers bytes with no last; MAX_PKT=4.
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    clr_logs();
    for (int c = 0; c < 5; c++) step(4'b0100, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, $urandom);
    chk("ovr_writes", 32'(n_wr), 32'd4);
    step(4'b1111, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, $urandom);
    chk("ovr_err", 32'(n_err), 32'd1);
    step(4'b0000, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, $urandom);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("ovr_next_grant", 32'(gq_at(1)), PRIO ? 32'h1 : 32'h8);
    chk("ovr_err_once", 32'(n_err), 32'd1);

    // Abort on byte 2 of owner 0; abort in FLUSH and IDLE is ignored.
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    clr_logs();
    step(4'b0011, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, $urandom);
    step(4'b0011, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, $urandom);
    step(4'b0011, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, $urandom);
    chk("abort_writes", 32'(n_wr), 32'd1);
    step(4'b0011, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, $urandom);
    step(4'b0011, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, $urandom);
    step(4'b0000, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, $urandom);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("abort_clears", 32'(n_clr), 32'd1);
    chk("abort_next_grant", 32'(gq_at(1)), PRIO ? 32'h1 : 32'h2);

    // Reset during byte 3 of owner 0: no clear, next search starts at 0.
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    clr_logs();
    for (int c = 0; c < 3; c++) step(4'b0001, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, $urandom);
    step(4'b0001, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, $urandom);
    step(4'b1111, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, $urandom);
    chk("rst_grant_drop", 32'(bus.grant), 32'h0);
    step(4'b0000, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, $urandom);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("rst_next_grant", 32'(gq_at(1)), 32'h1);
    chk("rst_no_clear", 32'(n_clr), 32'd0);

    // req=1001 held with single-byte packets.
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    clr_logs();
    for (int c = 0; c < 9; c++) step(4'b1001, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, $urandom);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("pri_g0", 32'(gq_at(0)), 32'h1);
    chk("pri_g1", 32'(gq_at(1)), PRIO ? 32'h1 : 32'h8);
    chk("pri_g2", 32'(gq_at(2)), 32'h1);

    // Random traffic against the model.
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rr = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom);
      step(rr, 4'($urandom | $urandom), 4'($urandom & $urandom),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 199) != 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
